axi_rd_arbiter: RTL and testbench

- Shares the single AXI read-address/read-data channel pair between two SRAM-like read requesters: instruction fetch (ID 0) and data load (ID 1).
- Grants one AR transaction at a time and tracks outstanding reads per requester.
- Routes R-channel beats back to the owner by rid.
- Blocks a data read that hits the address of an in-flight write (read-after-write hazard).
- Sits between the fetch/load stages and the AXI master port of the CPU top.

---
 rtl/axi_rd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: fetch (id 0) and load (id 1) share AR/R.
// Define RR_ARB_EN for round-robin grants; default is load-over-fetch priority.
module axi_rd_arbiter #(
  parameter int MAX_OUT = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_busy,
  input  logic [31:0] wr_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {IDLE, AR_BUSY} state_e;

  localparam logic [2:0] MaxCnt = 3'(MAX_OUT);

  state_e      state_q, state_d;
  logic [2:0]  inst_cnt_q, inst_cnt_d;
  logic [2:0]  data_cnt_q, data_cnt_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q;

  logic hazard, idle;
  logic data_elig, inst_elig;
  logic data_gnt, inst_gnt;
  logic r_done, inst_dec, data_dec;
  logic unused_bits;

  assign unused_bits = ^{rid[3:1], wr_addr[1:0], data_addr[1:0]};

  // Word-granular match against the in-flight store
  assign hazard = wr_busy &&
                  (wr_addr[31:2] == data_addr[31:2]);
  assign idle   = aresetn && (state_q == IDLE);

  assign data_elig = idle && data_req &&
                     (data_cnt_q < MaxCnt) && !hazard;
  assign inst_elig = idle && inst_req &&
                     (inst_cnt_q < MaxCnt);

`ifdef RR_ARB_EN
  logic last_grant_q, last_grant_d;

  assign data_gnt = data_elig &&
                    (!inst_elig || !last_grant_q);
  assign inst_gnt = inst_elig && !data_gnt;

  always_comb begin
    last_grant_d = last_grant_q;
    if (data_gnt)      last_grant_d = 1'b1;
    else if (inst_gnt) last_grant_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) last_grant_q <= 1'b0;
    else          last_grant_q <= last_grant_d;
  end
`else
  assign data_gnt = data_elig;
  assign inst_gnt = inst_elig && !data_elig;
`endif

  assign r_done   = rvalid && rready_q && rlast;
  assign inst_dec = r_done && !rid[0];
  assign data_dec = r_done && rid[0];

  function automatic logic [2:0] cnt_next(
    input logic [2:0] cnt,
    input logic       inc,
    input logic       dec
  );
    logic [2:0] n;
    n = cnt;
    if (inc && !dec)
      n = cnt + 3'd1;
    else if (dec && !inc && cnt != 3'd0)
      n = cnt - 3'd1;
    return n;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      inst_cnt_q <= 3'd0;
      data_cnt_q <= 3'd0;
      arid_q     <= 4'd0;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_gnt || inst_gnt)
          state_d = AR_BUSY;
      end
      AR_BUSY: begin
        if (arvalid_q && arready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    arvalid_d  = arvalid_q;
    unique case (1'b1)
      data_gnt: begin
        arid_d    = 4'd1;
        araddr_d  = data_addr;
        arsize_d  = {1'b0, data_size};
        arvalid_d = 1'b1;
      end
      inst_gnt: begin
        arid_d    = 4'd0;
        araddr_d  = inst_addr;
        arsize_d  = {1'b0, inst_size};
        arvalid_d = 1'b1;
      end
      default: begin
        if (state_q == AR_BUSY && arready)
          arvalid_d = 1'b0;
      end
    endcase
    inst_cnt_d = cnt_next(inst_cnt_q,
                          inst_gnt, inst_dec);
    data_cnt_d = cnt_next(data_cnt_q,
                          data_gnt, data_dec);
  end

  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt;
  assign inst_data_ok = rvalid && rready_q && !rid[0];
  assign data_data_ok = rvalid && rready_q && rid[0];
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = rready_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter with a transaction-level
// reference model and a random-order single-beat AXI read slave.
module tb_axi_rd_arbiter;
  localparam int MAX_OUT = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        inst_req, data_req;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        wr_busy;
  logic [31:0] wr_addr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_size(inst_size),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_size(data_size),
    .data_addr(data_addr),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [1:0]  size;
  } ar_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } r_t;

  int  cmp = 0;
  int  bad = 0;
  ar_t ar_q[$];
  r_t  r_q[$];
  bit  pend[$];
  int  m_out[2];
  bit  m_busy, m_rrdy, m_last, late_beat;
  ar_t m_cur;
  int  stall = 0;
  bit  rst_done = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (arvalid) begin
        if (ar_q.size() == 0) begin
          cmp++; bad++;
          $display("FAIL ar_unexpected: got arid %0h araddr %0h expected none",
                   arid, araddr);
        end else begin
          chk("ar_id", 64'(arid),
              64'({3'b0, ar_q[0].id}));
          chk("ar_addr", 64'(araddr),
              64'(ar_q[0].addr));
          chk("ar_size", 64'(arsize),
              64'({1'b0, ar_q[0].size}));
          chk("ar_const",
              64'({arlen, arburst, arlock,
                   arcache, arprot}),
              64'({8'd0, 2'b01, 2'd0,
                   4'd0, 3'd0}));
          if (arready) void'(ar_q.pop_front());
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (r_q.size() == 0) begin
          cmp++; bad++;
          $display("FAIL r_unexpected: got data_ok %b%b expected none",
                   inst_data_ok, data_data_ok);
        end else begin
          chk("r_route",
              64'({inst_data_ok, data_data_ok}),
              64'(r_q[0].id ? 2'b01 : 2'b10));
          chk("inst_rdata", 64'(inst_rdata),
              64'(r_q[0].data));
          chk("data_rdata", 64'(data_rdata),
              64'(r_q[0].data));
          void'(r_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    inst_req = 1'b1;
    data_req = 1'b1;
    wr_busy  = 1'b0;
    rvalid   = 1'b0;
    arready  = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("rst_data_addr_ok", 64'(data_addr_ok), 64'd0);
    chk("rst_ar_fields",
        64'({arid, araddr, arsize}), 64'd0);
    m_out[0] = 0;
    m_out[1] = 0;
    m_busy = 0;
    m_rrdy = 0;
    m_last = 0;
    ar_q.delete();
    r_q.delete();
    pend.delete();
    @(posedge aclk); #1;
    chk("rst_hold_arvalid", 64'(arvalid), 64'd0);
    chk("rst_hold_rready", 64'(rready), 64'd0);
    inst_req = 1'b0;
    data_req = 1'b0;
    aresetn  = 1'b1;
    @(posedge aclk); #1;
    chk("rready_after_rst", 64'(rready), 64'd1);
    m_rrdy = 1;
  endtask

  task automatic step(input bit allow);
    bit  de, ie, dg, ig, r_hs, r_id;
    int  idx;
    ar_t t;
    @(posedge aclk); #1;
    inst_req  = allow && ($urandom_range(0, 1) == 1);
    inst_addr = 32'h1C00_0000 +
                32'($urandom_range(0, 255)) * 4;
    inst_size = 2'($urandom_range(0, 2));
    data_req  = allow && ($urandom_range(0, 2) != 0);
    data_addr = 32'h1C00_8000 +
                32'($urandom_range(0, 7)) * 4 +
                32'($urandom_range(0, 3));
    data_size = 2'($urandom_range(0, 2));
    wr_busy   = ($urandom_range(0, 1) == 1);
    if ($urandom_range(0, 1) == 1)
      wr_addr = {data_addr[31:2],
                 2'($urandom_range(0, 3))};
    else
      wr_addr = 32'h1C00_8000 +
                32'($urandom_range(0, 7)) * 4;
    if (stall > 0) begin
      arready = 1'b0;
      stall--;
    end else begin
      arready = ($urandom_range(0, 3) != 0);
    end
    rvalid = 1'b0;
    rlast  = 1'($urandom_range(0, 1));
    rid    = 4'($urandom_range(0, 15));
    rdata  = $urandom;
    if (m_rrdy && late_beat) begin
      rvalid = 1'b1;
      rlast  = 1'b1;
      rid    = 4'd0;
      r_q.push_back('{id: 1'b0, data: rdata});
      late_beat = 0;
    end else if (m_rrdy && pend.size() > 0 &&
                 $urandom_range(0, 1) == 1) begin
      idx    = $urandom_range(0, pend.size() - 1);
      rid    = {3'($urandom_range(0, 7)), pend[idx]};
      rvalid = 1'b1;
      rlast  = 1'b1;
      r_q.push_back('{id: pend[idx], data: rdata});
      pend.delete(idx);
    end
    r_hs = rvalid && m_rrdy && rlast;
    r_id = rid[0];
    #3;
    de = !m_busy && data_req && m_out[1] < MAX_OUT &&
         !(wr_busy && wr_addr[31:2] == data_addr[31:2]);
    ie = !m_busy && inst_req && m_out[0] < MAX_OUT;
`ifdef RR_ARB_EN
    if (de && ie) begin
      dg = !m_last;
      ig = m_last;
    end else begin
      dg = de;
      ig = ie;
    end
`else
    dg = de;
    ig = ie && !de;
`endif
    chk("data_addr_ok", 64'(data_addr_ok), 64'(dg));
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(ig));
    chk("arvalid", 64'(arvalid), 64'(m_busy));
    chk("rready", 64'(rready), 64'(m_rrdy));
    if (m_busy && arready) begin
      pend.push_back(m_cur.id);
      m_busy = 0;
    end
    if (dg || ig) begin
      t = '{id: dg,
            addr: dg ? data_addr : inst_addr,
            size: dg ? data_size : inst_size};
      ar_q.push_back(t);
      m_cur  = t;
      m_busy = 1;
      m_out[dg ? 1 : 0]++;
      m_last = dg;
    end
    if (r_hs && m_out[r_id ? 1 : 0] > 0)
      m_out[r_id ? 1 : 0]--;
  endtask

  initial begin
    inst_req = 0; data_req = 0;
    inst_size = 0; data_size = 0;
    inst_addr = 0; data_addr = 0;
    wr_busy = 0; wr_addr = 0;
    arready = 0; rvalid = 0; rlast = 0;
    rid = 0; rdata = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 150) stall = 6;
      if (c >= 1500 && !rst_done && m_busy) begin
        do_reset();
        rst_done  = 1;
        late_beat = 1;
      end
      step(1'b1);
    end
    for (int c = 0; c < 300 &&
         (m_busy || pend.size() > 0 || late_beat); c++)
      step(1'b0);
    #2;
    cmp++;
    if (m_busy || pend.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               pend.size() + int'(m_busy));
    end
    chk("ar_sb_empty", 64'(ar_q.size()), 64'd0);
    chk("r_sb_empty", 64'(r_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, bad);
    $finish;
  end
endmodule
